// File: rtl/sb_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : sb_issue_queue
// Description : Scoreboard-side receiver of the decoder's id_to_sb_bus stream.
//               Buffers decoded instructions in an in-order circular FIFO,
//               back-pressures the decoder through stall, tracks a 64-entry
//               register busy table (GPR 0-31, HI/LO at index 32) and issues
//               the FIFO head once its operands and destination are
//               hazard-free.
//
// Ports       : clk           system clock, rising edge
//               reset         asynchronous, active-high
//               br_e          branch flush, discards all queued entries
//               inst_valid    decoder output is a legal instruction
//               id_to_sb_bus  decoded instruction
//               stall         backpressure to the decoder (queue full)
//               issue_valid   head entry is issuable this cycle
//               issue_ready   FU side accepts this cycle
//               issue_bus     head entry contents
//               wb_we         writeback completes
//               wb_addr       writeback destination, clears its busy bit
//               count         current occupancy
//
// Revision    : 1.0  initial release
// ============================================================================
module sb_issue_queue #(
    parameter int BUS_WD = 137,
    parameter int DEPTH  = 4,
    parameter int CNT_WD = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_e,
    input  logic              inst_valid,
    input  logic [BUS_WD-1:0] id_to_sb_bus,
    output logic              stall,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [BUS_WD-1:0] issue_bus,
    input  logic              wb_we,
    input  logic [5:0]        wb_addr,
    output logic [CNT_WD-1:0] count
);

    localparam int              c_PTR_WD = $clog2(DEPTH);
    localparam logic [CNT_WD-1:0] c_FULL = CNT_WD'(DEPTH);

    // Storage and bookkeeping state
    logic [BUS_WD-1:0]   r_mem [DEPTH];
    logic [c_PTR_WD-1:0] r_wr_ptr;
    logic [c_PTR_WD-1:0] r_rd_ptr;
    logic [CNT_WD-1:0]   r_count;
    logic [63:0]         r_busy;

    // Head-entry decode
    logic [BUS_WD-1:0] w_head;
    logic [5:0]        w_reg1;
    logic [5:0]        w_reg2;
    logic [5:0]        w_reg3;
    logic              w_r1_val;
    logic              w_r2_val;
    logic              w_rf_we;

    logic w_src1_ok;
    logic w_src2_ok;
    logic w_dst_ok;
    logic w_push;
    logic w_fire;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_reg1   = w_head[88:83];
    assign w_r1_val = w_head[82];
    assign w_reg2   = w_head[80:75];
    assign w_r2_val = w_head[74];
    assign w_reg3   = w_head[72:67];
    assign w_rf_we  = w_head[66];

    assign stall = (r_count == c_FULL);
    assign count = r_count;

    // A full queue refuses the push even if the head pops this same cycle;
    // a flush drops whatever the decoder is presenting.
    assign w_push = inst_valid & ~stall & ~br_e;

    // A writeback completing this cycle releases its register immediately,
    // so a waiting consumer can issue in the same cycle.
    assign w_src1_ok = ~w_r1_val | ~r_busy[w_reg1] | (wb_we & (wb_addr == w_reg1));
    assign w_src2_ok = ~w_r2_val | ~r_busy[w_reg2] | (wb_we & (wb_addr == w_reg2));
    assign w_dst_ok  = ~w_rf_we  | ~r_busy[w_reg3] | (wb_we & (wb_addr == w_reg3));

    assign issue_valid = (r_count != '0) & w_src1_ok & w_src2_ok & w_dst_ok & ~br_e;
    assign issue_bus   = w_head;
    assign w_fire      = issue_valid & issue_ready;

    // Entry storage: only accepted pushes are written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= id_to_sb_bus;
        end
    end

    // Pointers and occupancy; pointer width matches DEPTH so wrap is natural
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (br_e) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Busy table. Not cleared by a flush: instructions already issued will
    // still write back. The set is applied after the clear so a same-address
    // collision leaves the register busy for the new writer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (wb_we) begin
                r_busy[wb_addr] <= 1'b0;
            end
            if (w_fire && w_rf_we && (w_reg3 != 6'd0)) begin
                r_busy[w_reg3] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sb_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_issue_queue
// Description : Directed self-checking bench for sb_issue_queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sb_issue_queue;

    localparam int c_BUS_WD = 137;
    localparam int c_DEPTH  = 4;
    localparam int c_CNT_WD = 3;

    logic                clk;
    logic                rst;
    logic                br_e;
    logic                inst_valid;
    logic [c_BUS_WD-1:0] id_to_sb_bus;
    logic                stall;
    logic                issue_valid;
    logic                issue_ready;
    logic [c_BUS_WD-1:0] issue_bus;
    logic                wb_we;
    logic [5:0]          wb_addr;
    logic [c_CNT_WD-1:0] count;

    int checks;
    int errors;

    sb_issue_queue #(
        .BUS_WD (c_BUS_WD),
        .DEPTH  (c_DEPTH),
        .CNT_WD (c_CNT_WD)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .br_e         (br_e),
        .inst_valid   (inst_valid),
        .id_to_sb_bus (id_to_sb_bus),
        .stall        (stall),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_bus    (issue_bus),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_BUS_WD-1:0] mk(input logic [2:0] fu,
                                               input logic [5:0] r1, input logic r1v,
                                               input logic [5:0] r2, input logic r2v,
                                               input logic [5:0] r3, input logic we,
                                               input logic [31:0] pc);
        logic [c_BUS_WD-1:0] b;
        b        = '0;
        b[91:89] = fu;
        b[88:83] = r1;
        b[82]    = r1v;
        b[80:75] = r2;
        b[74]    = r2v;
        b[72:67] = r3;
        b[66]    = we;
        b[31:0]  = pc;
        return b;
    endfunction

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes
    task automatic settle();
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        br_e         = 1'b0;
        inst_valid   = 1'b0;
        id_to_sb_bus = '0;
        issue_ready  = 1'b0;
        wb_we        = 1'b0;
        wb_addr      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();

        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_bus", issue_bus[63:0], 64'd0);

        // Fill/drain: four accepted, fifth held
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inst_valid   = 1'b1;
            id_to_sb_bus = mk(3'd1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'hBFC0_0000 + 32'(4 * i));
            cyc();
            check("fill_count", 64'(count), 64'(i + 1));
        end
        check("fill_stall", 64'(stall), 64'd1);
        id_to_sb_bus = mk(3'd1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'hBFC0_0010);
        cyc();
        check("full_reject_count", 64'(count), 64'd4);
        // Pop while full with a push pending: the push is still refused
        issue_ready = 1'b1;
        settle();
        check("drain_valid0", 64'(issue_valid), 64'd1);
        check("drain_pc0", 64'(issue_bus[31:0]), 64'hBFC0_0000);
        cyc();
        check("pop_full_count", 64'(count), 64'd3);
        inst_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            settle();
            check("drain_valid", 64'(issue_valid), 64'd1);
            check("drain_pc", 64'(issue_bus[31:0]), 64'hBFC0_0000 + 64'(4 * k));
            cyc();
        end
        check("drain_count", 64'(count), 64'd0);
        check("drain_empty_valid", 64'(issue_valid), 64'd0);

        // RAW hazard with writeback bypass
        inst_valid   = 1'b1;
        id_to_sb_bus = mk(3'd1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd8, 1'b1, 32'h0000_0100);
        cyc();
        inst_valid = 1'b0;
        settle();
        check("addu_valid", 64'(issue_valid), 64'd1);
        cyc();
        check("addu_busy8", 64'(dut.r_busy[8]), 64'd1);
        inst_valid   = 1'b1;
        id_to_sb_bus = mk(3'd2, 6'd8, 1'b1, 6'd0, 1'b0, 6'd9, 1'b1, 32'h0000_0104);
        cyc();
        inst_valid = 1'b0;
        settle();
        check("raw_blocked", 64'(issue_valid), 64'd0);
        cyc();
        check("raw_still_blocked", 64'(issue_valid), 64'd0);
        wb_we   = 1'b1;
        wb_addr = 6'd8;
        settle();
        check("raw_bypass", 64'(issue_valid), 64'd1);
        cyc();
        wb_we = 1'b0;
        check("raw_count", 64'(count), 64'd0);
        check("raw_busy8_clr", 64'(dut.r_busy[8]), 64'd0);
        check("raw_busy9_set", 64'(dut.r_busy[9]), 64'd1);
        wb_we   = 1'b1;
        wb_addr = 6'd9;
        cyc();
        wb_we = 1'b0;

        // HI/LO: mult writes 32, mflo reads 32
        inst_valid   = 1'b1;
        id_to_sb_bus = mk(3'd3, 6'd4, 1'b1, 6'd5, 1'b1, 6'd32, 1'b1, 32'h0000_0200);
        cyc();
        inst_valid = 1'b0;
        cyc();
        check("mult_busy32", 64'(dut.r_busy[32]), 64'd1);
        inst_valid   = 1'b1;
        id_to_sb_bus = mk(3'd3, 6'd0, 1'b0, 6'd32, 1'b1, 6'd10, 1'b1, 32'h0000_0204);
        cyc();
        inst_valid = 1'b0;
        settle();
        check("mflo_blocked", 64'(issue_valid), 64'd0);
        wb_we   = 1'b1;
        wb_addr = 6'd32;
        settle();
        check("mflo_bypass", 64'(issue_valid), 64'd1);
        cyc();
        wb_we = 1'b0;
        check("mflo_busy10", 64'(dut.r_busy[10]), 64'd1);
        // WAW: another writer of r10 waits for its writeback
        inst_valid   = 1'b1;
        id_to_sb_bus = mk(3'd1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1, 32'h0000_0208);
        cyc();
        inst_valid = 1'b0;
        settle();
        check("waw_blocked", 64'(issue_valid), 64'd0);
        wb_we   = 1'b1;
        wb_addr = 6'd10;
        settle();
        check("waw_bypass", 64'(issue_valid), 64'd1);
        cyc();
        wb_we = 1'b0;
        check("set_wins_busy10", 64'(dut.r_busy[10]), 64'd1);
        wb_we   = 1'b1;
        wb_addr = 6'd10;
        cyc();
        wb_we = 1'b0;
        // Writer of r0 never marks it busy
        inst_valid   = 1'b1;
        id_to_sb_bus = mk(3'd1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 32'h0000_020C);
        cyc();
        inst_valid = 1'b0;
        cyc();
        check("r0_count", 64'(count), 64'd0);
        check("r0_not_busy", 64'(dut.r_busy[0]), 64'd0);

        // Flush with three queued, busy[5] set beforehand
        inst_valid   = 1'b1;
        id_to_sb_bus = mk(3'd1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, 32'h0000_0300);
        cyc();
        inst_valid = 1'b0;
        cyc();
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_valid   = 1'b1;
            id_to_sb_bus = mk(3'd1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0000_0310 + 32'(4 * i));
            cyc();
        end
        check("pre_flush_count", 64'(count), 64'd3);
        br_e         = 1'b1;
        issue_ready  = 1'b1;
        id_to_sb_bus = mk(3'd1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0000_0320);
        settle();
        check("flush_suppress", 64'(issue_valid), 64'd0);
        cyc();
        br_e       = 1'b0;
        inst_valid = 1'b0;
        settle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(issue_valid), 64'd0);
        check("flush_busy5", 64'(dut.r_busy[5]), 64'd1);

        // Back-to-back stream: one push and one issue per cycle
        issue_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inst_valid   = 1'b1;
            id_to_sb_bus = mk(3'd1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0000_0400 + 32'(4 * i));
            settle();
            if (i > 0) begin
                check("stream_valid", 64'(issue_valid), 64'd1);
                check("stream_pc", 64'(issue_bus[31:0]), 64'h400 + 64'(4 * (i - 1)));
            end
            cyc();
            check("stream_count", 64'(count), 64'd1);
        end
        inst_valid = 1'b0;
        settle();
        check("stream_last_pc", 64'(issue_bus[31:0]), 64'h424);
        cyc();
        check("stream_end_count", 64'(count), 64'd0);

        // Async reset between edges
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_valid   = 1'b1;
            id_to_sb_bus = mk(3'd1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0000_0500 + 32'(4 * i));
            cyc();
        end
        inst_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd3);
        check("pre_rst_busy5", 64'(dut.r_busy[5]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_valid", 64'(issue_valid), 64'd0);
        check("arst_busy", dut.r_busy, 64'd0);
        cyc();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_issue_queue.md
Name: sb_issue_queue

Overview:
- Scoreboard-side receiver of the decoder's id_to_sb_bus stream.
- Buffers decoded instructions in an in-order FIFO and drives the decoder's stall input.
- Tracks a 64-entry register busy table: GPR 0-31 and HI/LO at index 32.
- Issues the FIFO head to the function units when its source operands and destination are hazard-free.

Parameters:
- BUS_WD, 137, width of id_to_sb_bus (ID_TO_SB_WD).
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_WD, 3, width of count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- br_e  in  1  branch flush; discards all queued entries.
- inst_valid  in  1  decoder output is a legal instruction.
- id_to_sb_bus  in  BUS_WD  decoded instruction. Fields: fu 91:89, reg1 88:83, r1_val 82, reg2 80:75, r2_val 74, reg3 72:67, rf_we 66, pc 31:0.
- stall  out  1  backpressure to the decoder.
- issue_valid  out  1  head entry is issuable this cycle.
- issue_ready  in  1  FU side accepts this cycle.
- issue_bus  out  BUS_WD  head entry contents.
- wb_we  in  1  writeback completes.
- wb_addr  in  6  writeback destination; clears its busy bit.
- count  out  CNT_WD  current occupancy.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset (async assert): rd/wr pointers=0, count=0, all busy bits=0, stall=0, issue_valid=0, issue_bus=0.
- Storage: circular buffer of DEPTH x BUS_WD with wrap-around pointers. count is a registered occupancy counter.
- Full/empty:
  - stall = (count==DEPTH), combinational from count.
  - push = inst_valid & ~stall & ~br_e.
  - A push is rejected while full, even if a pop happens in the same cycle.
- Entries with inst_valid=0 are never written.
- Empty queue: issue_valid=0; issue_bus holds stale contents (don't-care).
- Hazard check on the head entry, with reg1/reg2/reg3 taken from the head fields:
  - src1_ok = ~r1_val | ~busy[reg1] | (wb_we & wb_addr==reg1).
  - src2_ok = ~r2_val | ~busy[reg2] | (wb_we & wb_addr==reg2).
  - dst_ok = ~rf_we | ~busy[reg3] | (wb_we & wb_addr==reg3). This is the WAW guard.
  - issue_valid = (count!=0) & src1_ok & src2_ok & dst_ok & ~br_e. Combinational; no registered delay.
- fire = issue_valid & issue_ready. On fire: rd pointer advances and count decrements.
- Issue is strictly in order; a blocked head blocks all younger entries.
- Busy table update each edge:
  - wb_we clears busy[wb_addr].
  - fire with rf_we & reg3!=0 sets busy[reg3].
  - Same address in both in the same cycle: set wins.
- busy[0] is never set; reg 0 always reads ready.
- Latency: an instruction pushed at edge N is visible at the head no earlier than cycle N+1. Minimum push-to-fire is 1 cycle on an empty queue.
- Simultaneous push and fire with count<DEPTH: count is unchanged and both pointers advance.
- br_e:
  - Next edge: pointers=0 and count=0.
  - Same-cycle push is dropped and same-cycle issue is suppressed.
  - Busy table is NOT cleared, because already-issued instructions still write back.
- issue_ready asserted while issue_valid=0 has no effect.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge.

Test Plan:
- Fill/drain: issue_ready=0, push 5 addiu entries.
  - Entries 1-4 are accepted; stall=1 at count=4; the 5th is held by the decoder.
  - With issue_ready=1, 4 issues follow in push order, with pc 0xBFC00000, +4, +8, +C.
- RAW hazard: issue addu reg3=8 (busy[8]=1), then push lw with reg1=8.
  - issue_valid stays 0 until wb_we=1, wb_addr=8.
  - issue_valid=1 in that same cycle via the bypass.
- WAW/HI-LO: issue mult with reg3=32, then mflo with reg2=32.
  - mflo is blocked until a writeback to addr 32.
  - A reg3=0 writer never sets busy[0].
- Flush: queue holds 3 entries and br_e=1 coincides with inst_valid=1 and issue_ready=1.
  - Next cycle count=0 and issue_valid=0; nothing was issued and the push was dropped.
  - Busy bits set earlier remain set.
- Wrap/simultaneous: stream 10 back-to-back independent ori with issue_ready=1.
  - One issue per cycle; count holds at 1; pointers wrap past DEPTH; all pc values are in order.
- Async reset: assert reset between edges while count=3 and busy[5]=1.
  - count=0, stall=0, issue_valid=0 and busy cleared before the next clk edge.
